vdp_tile_fetch: RTL and testbench

- Per-scanline DMA fetch scheduler for the VDP in Graphics I mode. Sequences name, pattern and colour reads into the vram DMA port (dma_addr / dma_rd_tick).
- Writes each tile's pattern and colour bytes into the line buffer that feeds the pixel shifter.
- Every 4-clock tile slot contains one guaranteed idle DMA cycle, so CPU rd_tick/wr_tick accesses to vram are never starved.

---
 rtl/vdp_pkg.sv | 14 +
 rtl/vdp_tile_fetch_if.sv | 32 +++
 rtl/vdp_fetch_addr.sv | 25 ++
 rtl/vdp_tile_fetch.sv | 111 +++++++++++
 tb/tb_vdp_tile_fetch.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/vdp_pkg.sv
// vdp_pkg: shared fetch states, table-base shifts and line geometry for the VDP
package vdp_pkg;
  localparam int VRAM_SIZE       = 8192;
  localparam int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE);
  localparam int TILES           = 32;
  localparam int ACTIVE_ROWS     = 192;
  localparam int NAME_SHIFT      = 10;
  localparam int PAT_SHIFT       = 11;
  localparam int COL_SHIFT       = 6;

  typedef enum logic [2:0] {
    IDLE, S_NAME, S_NWAIT, S_PAT, S_COL, S_DRAIN
  } state_t;
endpackage

// File: rtl/vdp_tile_fetch_if.sv
// vdp_tile_fetch_if: line control, register, DMA and line-buffer signals of the tile fetcher
interface vdp_tile_fetch_if import vdp_pkg::*; #(
  parameter int AW = VRAM_ADDR_WIDTH
);
  logic          line_start;
  logic          enable;
  logic [7:0]    row;
  logic [3:0]    name_base;
  logic [2:0]    pat_base;
  logic [7:0]    color_base;
  logic [7:0]    dma_dout;
  logic [AW-1:0] dma_addr;
  logic          dma_rd_tick;
  logic          cpu_slot;
  logic          lb_wr;
  logic [4:0]    lb_addr;
  logic [7:0]    lb_pat;
  logic [7:0]    lb_col;
  logic          busy;
  logic          done;
  logic          overrun;

  modport slave (
    input  line_start, enable, row, name_base, pat_base, color_base, dma_dout,
    output dma_addr, dma_rd_tick, cpu_slot, lb_wr, lb_addr, lb_pat, lb_col, busy, done, overrun
  );

  modport master (
    output line_start, enable, row, name_base, pat_base, color_base, dma_dout,
    input  dma_addr, dma_rd_tick, cpu_slot, lb_wr, lb_addr, lb_pat, lb_col, busy, done, overrun
  );
endinterface

// File: rtl/vdp_fetch_addr.sv
// vdp_fetch_addr: Graphics I name/pattern/colour DMA address for the current fetch state
module vdp_fetch_addr import vdp_pkg::*; #(
  parameter int AW = VRAM_ADDR_WIDTH
) (
  input  state_t        state_i,
  input  logic [3:0]    name_base_i,
  input  logic [2:0]    pat_base_i,
  input  logic [7:0]    color_base_i,
  input  logic [7:0]    row_i,
  input  logic [4:0]    tile_i,
  input  logic [7:0]    name_i,
  output logic [AW-1:0] addr_o
);
  logic [AW-1:0] name_a, pat_a, col_a;

  // table base OR'd with the in-table offset; bits beyond the VRAM range fall off
  always_comb begin
    name_a = AW'(32'(name_base_i) << NAME_SHIFT) | AW'({row_i[7:3], tile_i});
    pat_a  = AW'(32'(pat_base_i) << PAT_SHIFT) | AW'({name_i, row_i[2:0]});
    col_a  = AW'(32'(color_base_i) << COL_SHIFT) | AW'(name_i[7:3]);
    addr_o = state_i == S_NAME ? name_a :
             state_i == S_PAT  ? pat_a  :
             state_i == S_COL  ? col_a  : '0;
  end
endmodule

// File: rtl/vdp_tile_fetch.sv
// vdp_tile_fetch: per-scanline name/pattern/colour DMA scheduler feeding the line buffer
module vdp_tile_fetch #(
  parameter int VRAM_SIZE       = 8192,
  parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE),
  parameter int TILES           = 32
) (
  input logic            clk,
  input logic            reset,
  vdp_tile_fetch_if.slave bus
);
  import vdp_pkg::*;

  state_t                     state_q, state_d;
  logic [4:0]                 tile_q, tile_d;
  logic [7:0]                 row_q, name_q, pat_q, cb_q;
  logic [3:0]                 nb_q;
  logic [2:0]                 pb_q;
  logic                       done_q, overrun_q;
  logic                       start, last, rd, wr, busy;
  logic [VRAM_ADDR_WIDTH-1:0] addr;

  assign busy  = state_q != IDLE || done_q;
  assign start = bus.line_start && !busy && bus.enable && bus.row < 8'(ACTIVE_ROWS);
  assign last  = tile_q == 5'(TILES - 1);

  // next state, tile counter and per-state DMA / line-buffer strobes
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start ? S_NAME : IDLE;
        tile_d  = '0;
      end
      S_NAME: begin
        state_d = S_NWAIT;
        rd      = 1'b1;
        wr      = tile_q != '0;
      end
      S_NWAIT: state_d = S_PAT;
      S_PAT: begin
        state_d = S_COL;
        rd      = 1'b1;
      end
      S_COL: begin
        state_d = last ? S_DRAIN : S_NAME;
        tile_d  = last ? tile_q : tile_q + 5'd1;
        rd      = 1'b1;
      end
      S_DRAIN: begin
        state_d = IDLE;
        wr      = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, line parameters latched at start, and the name/pattern bytes returned by DMA
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tile_q    <= '0;
      row_q     <= '0;
      nb_q      <= '0;
      pb_q      <= '0;
      cb_q      <= '0;
      name_q    <= '0;
      pat_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      done_q    <= state_q == S_DRAIN;
      overrun_q <= overrun_q | (bus.line_start & busy);
      if (start) begin
        row_q <= bus.row;
        nb_q  <= bus.name_base;
        pb_q  <= bus.pat_base;
        cb_q  <= bus.color_base;
      end
      if (state_q == S_NWAIT) name_q <= bus.dma_dout;
      if (state_q == S_COL) pat_q <= bus.dma_dout;
    end
  end

  vdp_fetch_addr #(.AW(VRAM_ADDR_WIDTH)) u_addr (
    .state_i      (state_q),
    .name_base_i  (nb_q),
    .pat_base_i   (pb_q),
    .color_base_i (cb_q),
    .row_i        (row_q),
    .tile_i       (tile_q),
    .name_i       (name_q),
    .addr_o       (addr)
  );

  // the colour byte is written straight from the DMA return, so no colour register is needed
  assign bus.dma_addr    = addr;
  assign bus.dma_rd_tick = rd;
  assign bus.cpu_slot    = !rd;
  assign bus.lb_wr       = wr;
  assign bus.lb_addr     = !wr ? '0 : state_q == S_DRAIN ? tile_q : tile_q - 5'd1;
  assign bus.lb_pat      = wr ? pat_q : '0;
  assign bus.lb_col      = wr ? bus.dma_dout : '0;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_vdp_tile_fetch.sv
// tb_vdp_tile_fetch: randomized scanline fetches checked against a table-lookup model of Graphics I
module tb_vdp_tile_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_q;
  logic [7:0]  vram [8192];
  logic [12:0] fa [3];
  logic [7:0]  fp, fc;
  bit          ov_exp;
  int          checks, errors;

  vdp_tile_fetch_if bus ();

  vdp_tile_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // vram: DMA and CPU reads both return data the clock after their tick
  always @(posedge clk) begin
    if (bus.dma_rd_tick) bus.dma_dout <= vram[bus.dma_addr];
    if (cpu_rd) cpu_q <= vram[cpu_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_line(input logic [7:0] r, input logic [3:0] nb, input logic [2:0] pb,
                          input logic [7:0] cb, input bit en, input int ls2_at, input int rst_at);
    logic [12:0] ea[$];
    logic [7:0]  ep[$], ec[$];
    int          ai, wi, ndone, done_k, na, pa, ca;
    bit          f, cpu_pend, exp_rd;
    logic [7:0]  nm, cpu_exp;
    f = en && r < 192;
    ai = 0; wi = 0; ndone = 0; done_k = -1; cpu_pend = 0; cpu_exp = '0;
    if (f)
      for (int t = 0; t < 32; t++) begin
        na = (int'(nb) * 1024 + int'(r) / 8 * 32 + t) % 8192;
        nm = vram[na];
        pa = (int'(pb) * 2048 + int'(nm) * 8 + int'(r) % 8) % 8192;
        ca = (int'(cb) * 64 + int'(nm) / 8) % 8192;
        ea.push_back(13'(na));
        ea.push_back(13'(pa));
        ea.push_back(13'(ca));
        ep.push_back(vram[pa]);
        ec.push_back(vram[ca]);
      end
    @(negedge clk);
    bus.line_start = 1'b1;
    bus.enable     = en;
    bus.row        = r;
    bus.name_base  = nb;
    bus.pat_base   = pb;
    bus.color_base = cb;
    @(negedge clk);
    bus.row        = 8'($urandom);
    bus.name_base  = ~nb;
    bus.pat_base   = ~pb;
    bus.color_base = ~cb;
    bus.enable     = 1'($urandom);
    for (int k = 0; k < 140; k++) begin
      bus.line_start = k == ls2_at;
      if (k == ls2_at) begin
        bus.row = 8'($urandom);
        ov_exp  = ov_exp || f;
      end
      if (k == rst_at) begin
        cpu_rd = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_rd_tick", bus.dma_rd_tick, 0);
        chk("rst_cpu_slot", bus.cpu_slot, 1);
        chk("rst_lb_wr", bus.lb_wr, 0);
        chk("rst_lb_addr", bus.lb_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_dma_addr", bus.dma_addr, 0);
        ov_exp = 1'b0;
        bus.line_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (cpu_pend) chk("cpu_read", cpu_q, cpu_exp);
      cpu_pend = 1'b0;
      cpu_rd   = 1'b0;
      exp_rd   = f && k < 128 && k % 4 != 1;
      chk("dma_rd_tick", bus.dma_rd_tick, exp_rd);
      chk("cpu_slot", bus.cpu_slot, !exp_rd);
      chk("busy", bus.busy, f && k <= 129);
      if (bus.dma_rd_tick) begin
        chk("dma_addr", bus.dma_addr, ai < ea.size() ? ea[ai] : 'x);
        if (ai < 3) fa[ai] = bus.dma_addr;
        ai++;
      end
      if (bus.lb_wr) begin
        chk("lb_addr", bus.lb_addr, wi);
        chk("lb_pat", bus.lb_pat, wi < ep.size() ? ep[wi] : 'x);
        chk("lb_col", bus.lb_col, wi < ec.size() ? ec[wi] : 'x);
        if (wi == 0) begin
          fp = bus.lb_pat;
          fc = bus.lb_col;
        end
        wi++;
      end
      if (bus.done) begin
        ndone++;
        done_k = k;
      end
      if (k < 139 && bus.cpu_slot && $urandom_range(1) == 1) begin
        cpu_rd   = 1'b1;
        cpu_addr = 13'($urandom);
        cpu_exp  = vram[cpu_addr];
        cpu_pend = 1'b1;
      end
      @(negedge clk);
    end
    chk("n_dma_reads", ai, f ? 96 : 0);
    chk("n_lb_writes", wi, f ? 32 : 0);
    chk("n_done", ndone, f ? 1 : 0);
    if (f) chk("done_latency", done_k, 129);
    chk("overrun", bus.overrun, ov_exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ov_exp = 1'b0;
    cpu_rd = 1'b0;
    cpu_addr = '0;
    bus.line_start = 1'b0;
    bus.enable = 1'b0;
    bus.row = '0;
    bus.name_base = '0;
    bus.pat_base = '0;
    bus.color_base = '0;
    for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
    vram[13'h1820] = 8'h01;
    vram[13'h0009] = 8'hF6;
    vram[13'h0000] = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rd_tick", bus.dma_rd_tick, 0);
    chk("reset_cpu_slot", bus.cpu_slot, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_dma_addr", bus.dma_addr, 0);
    reset = 1'b1;
    run_line(8'd9, 4'd6, 3'd0, 8'h80, 1'b1, -1, -1);
    chk("t0_name_addr", fa[0], 13'h1820);
    chk("t0_pat_addr", fa[1], 13'h0009);
    chk("t0_col_addr", fa[2], 13'h0000);
    chk("t0_lb_pat", fp, 8'hF6);
    chk("t0_lb_col", fc, 8'h00);
    repeat (3) run_line(8'($urandom_range(191)), 4'($urandom), 3'($urandom), 8'($urandom), 1'b1, -1, -1);
    run_line(8'd191, 4'($urandom), 3'($urandom), 8'($urandom), 1'b1, -1, -1);
    run_line(8'd192, 4'($urandom), 3'($urandom), 8'($urandom), 1'b1, -1, -1);
    run_line(8'($urandom_range(191)), 4'($urandom), 3'($urandom), 8'($urandom), 1'b0, -1, -1);
    run_line(8'($urandom_range(191)), 4'($urandom), 3'($urandom), 8'($urandom), 1'b1, 40, -1);
    run_line(8'($urandom_range(191)), 4'($urandom), 3'($urandom), 8'($urandom), 1'b1, -1, 20);
    run_line(8'($urandom_range(191)), 4'($urandom), 3'($urandom), 8'($urandom), 1'b1, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
